// File: rtl/ex_wb_buffer_pkg.sv
// ex_wb_buffer_pkg: shared widths, writeback entry layout and debug fill pattern
package ex_wb_buffer_pkg;
  localparam int DEF_DATAPATH_WIDTH = 64;
  localparam int DEF_REG_ADDR_WIDTH = 5;
  localparam int DEF_CNT_WIDTH = 32;
  localparam logic [63:0] DEBUG_PATTERN = 64'hDEAD_BEEF_DEAD_BEEF;
  typedef struct packed {
    logic [DEF_DATAPATH_WIDTH-1:0] data;
    logic [DEF_REG_ADDR_WIDTH-1:0] rd;
    logic we;
  } wb_entry_t;
endpackage

// File: rtl/ex_wb_buffer_skid.sv
// skid_buffer_2: generic two-entry (main + skid) valid/ready buffer with registered ready
module skid_buffer_2
  import ex_wb_buffer_pkg::*;
#(
  parameter int W = DEF_DATAPATH_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic         skid_valid_o,
  output logic [W-1:0] skid_data_o
);
  logic main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic [W-1:0] main_q, main_d, skid_q, skid_d;
  logic push, pop;
  assign push = in_valid_i & ~skid_v_q;
  assign pop = main_v_q & out_ready_i;
  assign in_ready_o = ~skid_v_q;
  assign out_valid_o = main_v_q;
  assign out_data_o = main_q;
  assign skid_valid_o = skid_v_q;
  assign skid_data_o = skid_q;
  // FIFO next state: flush wins, skid drains into main, new data fills the first free slot
  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d = main_q;
    skid_d = skid_q;
    if (flush_i) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (skid_v_q) begin
      if (pop) begin
        main_d = skid_q;
        skid_v_d = 1'b0;
      end
    end else if (main_v_q) begin
      if (pop && push) main_d = in_data_i;
      else if (pop) main_v_d = 1'b0;
      else if (push) begin
        skid_d = in_data_i;
        skid_v_d = 1'b1;
      end
    end else if (push) begin
      main_d = in_data_i;
      main_v_d = 1'b1;
    end
  end
  // Entry storage, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end
endmodule

// File: rtl/ex_wb_buffer.sv
// ex_wb_buffer: execute-to-writeback skid stage with branch resolve, operand bypass and retire count
module ex_wb_buffer
  import ex_wb_buffer_pkg::*;
#(
  parameter int DATAPATH_WIDTH = DEF_DATAPATH_WIDTH,
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_in,
  input  logic                      ex_valid_in,
  output logic                      ex_ready_out,
  input  logic [DATAPATH_WIDTH-1:0] alu_result_in,
  input  logic                      alu_zero_in,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_in,
  input  logic                      reg_we_in,
  input  logic                      branch_in,
  output logic                      wb_valid_out,
  input  logic                      wb_ready_in,
  output logic [DATAPATH_WIDTH-1:0] wb_data_out,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd_addr_out,
  output logic                      wb_we_out,
  output logic                      branch_taken_out,
  output logic                      fwd_valid_out,
  output logic [REG_ADDR_WIDTH-1:0] fwd_rd_addr_out,
  output logic [DATAPATH_WIDTH-1:0] fwd_data_out,
  output logic [CNT_WIDTH-1:0]      retired_cnt_out
);
  localparam int EW = DATAPATH_WIDTH + REG_ADDR_WIDTH + 1;
  logic [EW-1:0] in_ent, main_ent, skid_ent;
  logic skid_v, accept, pop, skid_fwd, main_fwd;
  logic branch_q, branch_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  assign in_ent = {reg_we_in, rd_addr_in, alu_result_in};
  assign accept = ex_valid_in & ex_ready_out;
  assign pop = wb_valid_out & wb_ready_in;
  skid_buffer_2 #(.W(EW)) u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_in),
    .in_valid_i   (ex_valid_in & ~branch_in),
    .in_ready_o   (ex_ready_out),
    .in_data_i    (in_ent),
    .out_valid_o  (wb_valid_out),
    .out_ready_i  (wb_ready_in),
    .out_data_o   (main_ent),
    .skid_valid_o (skid_v),
    .skid_data_o  (skid_ent)
  );
  assign {wb_we_out, wb_rd_addr_out, wb_data_out} = main_ent;
  assign skid_fwd = skid_v & skid_ent[EW-1];
  assign main_fwd = wb_valid_out & main_ent[EW-1];
  assign fwd_valid_out = skid_fwd | main_fwd;
  assign fwd_rd_addr_out = skid_fwd ? skid_ent[EW-2:DATAPATH_WIDTH] :
                           main_fwd ? main_ent[EW-2:DATAPATH_WIDTH] : '0;
  assign fwd_data_out = skid_fwd ? skid_ent[DATAPATH_WIDTH-1:0] :
                        main_fwd ? main_ent[DATAPATH_WIDTH-1:0] : '0;
  assign branch_taken_out = branch_q;
  assign retired_cnt_out = cnt_q;
  // Redirect pulse for taken branches (suppressed by flush) and retire counter increment
  always_comb begin
    branch_d = accept & branch_in & alu_zero_in & ~flush_in;
    cnt_d = cnt_q + CNT_WIDTH'(pop);
  end
  // Pulse and counter registers; only reset clears the counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      branch_q <= branch_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
